// File: rtl/tile_map_writer.sv
// tile_map_writer: debounced four-button cursor mover for the 40x30 tile map.
// Each accepted move is written during vertical blanking as two back-to-back
// single-cycle writes: erase the old cell, then draw the new one.
module tile_map_writer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [3:0]  BG_TILE         = 4'd0,
  parameter logic [3:0]  CURSOR_TILE     = 4'd1,
  parameter logic [9:0]  VIS_FIRST       = 10'd32,
  parameter logic [9:0]  VIS_LAST        = 10'd511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upb,
  input  logic        downb,
  input  logic        leftb,
  input  logic        rightb,
  input  logic [9:0]  vcount,
  output logic        we,
  output logic [12:0] waddr,
  output logic [3:0]  wdata,
  output logic [3:0]  direction,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned COL_W   = 6;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned ADDR_W  = 13;
  // Counter only needs to hold 0..DEBOUNCE_CYCLES-1; it flips on the last count.
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(39);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(29);

  // One-hot direction codes, bit order {up, down, left, right}.
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_DRAW,
    S_IDLE,
    S_WAIT_VB,
    S_ERASE,
    S_DRAW
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync_lvl;
  logic [NUM_BTN-1:0] db_lvl;
  logic [NUM_BTN-1:0] db_prev;
  logic [CNT_W-1:0]   db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] press_c;

  logic [3:0]        sel_dir;
  logic [COL_W-1:0]  tgt_col;
  logic [ROW_W-1:0]  tgt_row;
  logic              tgt_ok;
  logic [COL_W-1:0]  tgt_col_q;
  logic [ROW_W-1:0]  tgt_row_q;

  logic              vblank_c;
  logic              dir_load;
  logic              tgt_load;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [3:0]        wdata_d;

  // Tile address row*40 + col built from shifts and adds.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
    return (ADDR_W'(row) << 5) + (ADDR_W'(row) << 3) + ADDR_W'(col);
  endfunction

  assign btn_raw  = {upb, downb, leftb, rightb};
  assign vblank_c = (vcount < VIS_FIRST) || (vcount > VIS_LAST);

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_lvl  <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_lvl  <= sync_meta;
    end
  end

  // Per-button debouncer: flip the level after DEBOUNCE_CYCLES disagreeing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_lvl  <= '0;
      db_prev <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_prev <= db_lvl;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_lvl[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_lvl[i] <= sync_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press event is the cycle the debounced level first reads high.
  assign press_c = db_lvl & ~db_prev;

  // Resolve simultaneous presses: up > down > left > right.
  always_comb begin
    sel_dir = '0;
    if (press_c[3]) begin
      sel_dir = DIR_UP;
    end else if (press_c[2]) begin
      sel_dir = DIR_DOWN;
    end else if (press_c[1]) begin
      sel_dir = DIR_LEFT;
    end else if (press_c[0]) begin
      sel_dir = DIR_RIGHT;
    end
  end

  // Target cell for the selected direction and whether it stays on the grid.
  always_comb begin
    tgt_col = cursor_col;
    tgt_row = cursor_row;
    tgt_ok  = 1'b0;
    case (sel_dir)
      DIR_UP: begin
        tgt_ok  = (cursor_row != '0);
        tgt_row = cursor_row - ROW_W'(1);
      end
      DIR_DOWN: begin
        tgt_ok  = (cursor_row != LAST_ROW);
        tgt_row = cursor_row + ROW_W'(1);
      end
      DIR_LEFT: begin
        tgt_ok  = (cursor_col != '0);
        tgt_col = cursor_col - COL_W'(1);
      end
      DIR_RIGHT: begin
        tgt_ok  = (cursor_col != LAST_COL);
        tgt_col = cursor_col + COL_W'(1);
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT_WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the write to present when the next state is entered.
  always_comb begin
    next_state = state;
    dir_load   = 1'b0;
    tgt_load   = 1'b0;
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;

    case (state)
      S_INIT_WAIT: if (vblank_c) next_state = S_INIT_DRAW;
      S_INIT_DRAW: next_state = S_IDLE;
      S_IDLE: begin
        if (sel_dir != '0) begin
          dir_load = 1'b1;
          if (tgt_ok) begin
            tgt_load   = 1'b1;
            next_state = S_WAIT_VB;
          end
        end
      end
      S_WAIT_VB:   if (vblank_c) next_state = S_ERASE;
      S_ERASE:     next_state = S_DRAW;
      S_DRAW:      next_state = S_IDLE;
      default:     next_state = S_INIT_WAIT;
    endcase

    // Writes are registered, so they are set up on entry into the write state.
    case (next_state)
      S_INIT_DRAW: begin
        we_d    = 1'b1;
        waddr_d = cell_addr('0, '0);
        wdata_d = CURSOR_TILE;
      end
      S_ERASE: begin
        we_d    = 1'b1;
        waddr_d = cell_addr(cursor_col, cursor_row);
        wdata_d = BG_TILE;
      end
      S_DRAW: begin
        we_d    = 1'b1;
        waddr_d = cell_addr(tgt_col_q, tgt_row_q);
        wdata_d = CURSOR_TILE;
      end
      default: ;
    endcase
  end

  // Registered write port and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      busy  <= 1'b1;
    end else begin
      we    <= we_d;
      waddr <= waddr_d;
      wdata <= wdata_d;
      busy  <= (next_state != S_IDLE);
    end
  end

  // Direction, latched target and cursor position.
  always_ff @(posedge clk) begin
    if (reset) begin
      direction  <= '0;
      tgt_col_q  <= '0;
      tgt_row_q  <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      if (dir_load) direction <= sel_dir;
      if (tgt_load) begin
        tgt_col_q <= tgt_col;
        tgt_row_q <= tgt_row;
      end
      if (state == S_DRAW) begin
        cursor_col <= tgt_col_q;
        cursor_row <= tgt_row_q;
      end
    end
  end

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer with a 4-cycle debounce.
module tb_tile_map_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        upb, downb, leftb, rightb;
  logic [9:0]  vcount;
  logic        we;
  logic [12:0] waddr;
  logic [3:0]  wdata;
  logic [3:0]  direction;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int n_we;

  tile_map_writer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .upb        (upb),
    .downb      (downb),
    .leftb      (leftb),
    .rightb     (rightb),
    .vcount     (vcount),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .direction  (direction),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {upb, downb, leftb, rightb} = b;
  endtask

  // Count write pulses over a number of cycles.
  task automatic count_we(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (we === 1'b1) n++;
      tick();
    end
  endtask

  // One button press with vcount already in blanking; checks exact latency.
  task automatic move(input string tag, input logic [3:0] btn, input logic [3:0] dir,
                      input bit wr, input int a_old, input int a_new,
                      input int col, input int row);
    int n;
    set_btn(btn);
    repeat (6) tick();
    check({tag, "/pre_busy"}, 32'(busy), 0);
    tick();
    check({tag, "/dir"}, 32'(direction), 32'(dir));
    check({tag, "/busy"}, 32'(busy), 32'(wr));
    check({tag, "/we_idle"}, 32'(we), 0);
    if (wr) begin
      tick();
      check({tag, "/erase_we"}, 32'(we), 1);
      check({tag, "/erase_addr"}, 32'(waddr), a_old);
      check({tag, "/erase_data"}, 32'(wdata), 0);
      tick();
      check({tag, "/draw_we"}, 32'(we), 1);
      check({tag, "/draw_addr"}, 32'(waddr), a_new);
      check({tag, "/draw_data"}, 32'(wdata), 1);
      tick();
      check({tag, "/done_we"}, 32'(we), 0);
      check({tag, "/done_busy"}, 32'(busy), 0);
    end else begin
      count_we(4, n);
      check({tag, "/no_write"}, n, 0);
      check({tag, "/still_idle"}, 32'(busy), 0);
    end
    check({tag, "/col"}, 32'(cursor_col), col);
    check({tag, "/row"}, 32'(cursor_row), row);
    set_btn(4'b0000);
    repeat (12) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    vcount = 10'd100;
    set_btn(4'b0000);
    repeat (3) tick();
    check("rst_we", 32'(we), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_dir", 32'(direction), 0);
    check("rst_col", 32'(cursor_col), 0);
    check("rst_row", 32'(cursor_row), 0);
    check("rst_busy", 32'(busy), 1);

    // Initial draw waits for blanking.
    reset = 1'b0;
    count_we(10, n_we);
    check("init_visible_no_we", n_we, 0);
    check("init_visible_busy", 32'(busy), 1);
    vcount = 10'd0;
    tick();
    check("init_we", 32'(we), 1);
    check("init_waddr", 32'(waddr), 0);
    check("init_wdata", 32'(wdata), 1);
    tick();
    check("init_we_off", 32'(we), 0);
    check("init_busy_off", 32'(busy), 0);

    vcount = 10'd5;
    move("clamp_up",   4'b1000, 4'b1000, 0, 0, 0, 0, 0);
    move("clamp_left", 4'b0010, 4'b0010, 0, 0, 0, 0, 0);
    move("right",      4'b0001, 4'b0001, 1, 0, 1, 1, 0);
    move("left_back",  4'b0010, 4'b0010, 1, 1, 0, 0, 0);
    move("down_left",  4'b0110, 4'b0100, 1, 0, 40, 0, 1);

    // Three-cycle glitch never reaches the debounce threshold.
    set_btn(4'b0001);
    repeat (3) tick();
    set_btn(4'b0000);
    count_we(20, n_we);
    check("glitch_no_we", n_we, 0);
    check("glitch_dir", 32'(direction), 32'(4'b0100));
    check("glitch_col", 32'(cursor_col), 0);

    // Long hold gives exactly one move.
    set_btn(4'b0001);
    count_we(100, n_we);
    set_btn(4'b0000);
    repeat (12) tick();
    check("hold_we_count", n_we, 2);
    check("hold_col", 32'(cursor_col), 1);
    check("hold_row", 32'(cursor_row), 1);
    check("hold_dir", 32'(direction), 32'(4'b0001));

    // Press during visible lines waits for vcount 512.
    vcount = 10'd200;
    set_btn(4'b1000);
    repeat (7) tick();
    check("vis_busy", 32'(busy), 1);
    check("vis_dir", 32'(direction), 32'(4'b1000));
    set_btn(4'b0000);
    count_we(20, n_we);
    check("vis_200_no_we", n_we, 0);
    vcount = 10'd32;
    count_we(3, n_we);
    check("vis_32_no_we", n_we, 0);
    vcount = 10'd511;
    count_we(3, n_we);
    check("vis_511_no_we", n_we, 0);
    check("vis_511_busy", 32'(busy), 1);
    vcount = 10'd512;
    tick();
    check("vb512_erase_we", 32'(we), 1);
    check("vb512_erase_addr", 32'(waddr), 41);
    check("vb512_erase_data", 32'(wdata), 0);
    tick();
    check("vb512_draw_we", 32'(we), 1);
    check("vb512_draw_addr", 32'(waddr), 1);
    check("vb512_draw_data", 32'(wdata), 1);
    tick();
    check("vb512_busy", 32'(busy), 0);
    check("vb512_row", 32'(cursor_row), 0);
    check("vb512_col", 32'(cursor_col), 1);
    vcount = 10'd5;
    repeat (12) tick();

    // Walk to the far corner.
    for (int c = 1; c < 39; c++) begin
      move("walk_right", 4'b0001, 4'b0001, 1, c, c + 1, c + 1, 0);
    end
    for (int r = 0; r < 28; r++) begin
      move("walk_down", 4'b0100, 4'b0100, 1, r * 40 + 39, (r + 1) * 40 + 39, 39, r + 1);
    end
    move("corner_draw",  4'b0100, 4'b0100, 1, 1159, 1199, 39, 29);
    move("corner_right", 4'b0001, 4'b0001, 0, 0, 0, 39, 29);
    move("corner_down",  4'b0100, 4'b0100, 0, 0, 0, 39, 29);

    // Reset while a move is pending.
    vcount = 10'd200;
    set_btn(4'b0010);
    repeat (7) tick();
    check("midrst_pending", 32'(busy), 1);
    reset = 1'b1;
    set_btn(4'b0000);
    tick();
    check("midrst_col", 32'(cursor_col), 0);
    check("midrst_row", 32'(cursor_row), 0);
    check("midrst_busy", 32'(busy), 1);
    check("midrst_we", 32'(we), 0);
    check("midrst_dir", 32'(direction), 0);
    vcount = 10'd0;
    reset  = 1'b0;
    tick();
    check("midrst_init_we", 32'(we), 1);
    check("midrst_init_addr", 32'(waddr), 0);
    check("midrst_init_data", 32'(wdata), 1);
    tick();
    check("midrst_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
